// File: rtl/fwd_pkg.sv
// ============================================================================
// Module  : fwd_pkg
// Brief   : Shared types and helpers for the forwarding scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fwd_pkg;

  // Entry fields are sized for the largest supported configuration.
  localparam int FWD_RD_W   = 8;
  localparam int FWD_LAT_W  = 8;
  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic                 valid;
    logic [FWD_RD_W-1:0]  rd;
    logic [FWD_LAT_W-1:0] rdy_at;
  } fwd_entry_t;

  function automatic logic [FWD_LAT_W-1:0] fwd_clamp(input logic [FWD_LAT_W-1:0] lat,
                                                     input int depth);
    if (lat == '0) begin
      return FWD_LAT_W'(1);
    end else if (int'(lat) > depth) begin
      return FWD_LAT_W'(depth);
    end else begin
      return lat;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_scoreboard_match.sv
// ============================================================================
// Module  : fwd_match
// Brief   : Youngest-producer priority match for one source operand.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fwd_match
  import fwd_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int AW    = 5,
  parameter int SW    = 2
) (
  input  fwd_entry_t [DEPTH:1] ent_i,
  input  logic                 used_i,
  input  logic [AW-1:0]        addr_i,
  output logic                 hit_o,
  output logic [SW-1:0]        sel_o,
  output logic                 stall_o
);

  // The oldest entry is already in the register file and never matches.
  logic unused_oldest;
  assign unused_oldest = ^ent_i[DEPTH];

  // Scan oldest to youngest so the smallest stage index overwrites the result.
  always_comb begin
    hit_o   = 1'b0;
    sel_o   = SW'(FWD_SEL_RF);
    stall_o = 1'b0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (used_i && (addr_i != '0) && ent_i[k].valid &&
          (ent_i[k].rd == FWD_RD_W'(addr_i))) begin
        hit_o   = 1'b1;
        sel_o   = SW'(k + 1);
        stall_o = (ent_i[k].rdy_at > FWD_LAT_W'(k + 1));
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fwd_scoreboard.sv
// ============================================================================
// Module  : fwd_scoreboard
// Brief   : Parametrised in-flight writer tracker with per-operand forward
//           select and self-inserted load-use bubble. FWD_PERF_CNT_EN adds
//           saturating stall/forward counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS),
  parameter int DEPTH    = 3,
  parameter int NUM_SRC  = 2,
  parameter int SW       = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  hold_i,
  input  logic                  flush_i,
  input  logic                  iss_valid_i,
  input  logic                  iss_regwrite_i,
  input  logic [AW-1:0]         iss_rd_i,
  input  logic [SW-1:0]         iss_lat_i,
  input  logic [NUM_SRC*AW-1:0] src_addr_i,
  input  logic [NUM_SRC-1:0]    src_used_i,
  output logic [NUM_SRC*SW-1:0] fwd_sel_o,
  output logic                  stall_o
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           fwd_cnt_o
`endif
);

  fwd_entry_t [DEPTH:1]  ent_q, ent_d;
  logic [NUM_SRC*SW-1:0] fwd_sel_q, fwd_sel_d;
  logic [NUM_SRC-1:0]    op_hit, op_stall;
  logic [NUM_SRC*SW-1:0] op_sel;
  logic                  issue;

  genvar j;
  generate
    for (j = 0; j < NUM_SRC; j++) begin : g_src
      fwd_match #(.DEPTH(DEPTH), .AW(AW), .SW(SW)) u_match (
        .ent_i   (ent_q),
        .used_i  (src_used_i[j]),
        .addr_i  (src_addr_i[j*AW +: AW]),
        .hit_o   (op_hit[j]),
        .sel_o   (op_sel[j*SW +: SW]),
        .stall_o (op_stall[j])
      );
    end
  endgenerate

  assign stall_o = iss_valid_i & ~flush_i & (|op_stall);
  assign issue   = iss_valid_i & ~stall_o & ~flush_i & ~hold_i;

  always_comb begin
    ent_d     = ent_q;
    fwd_sel_d = fwd_sel_q;
    if (!hold_i) begin
      for (int k = DEPTH; k >= 2; k--) begin
        ent_d[k] = ent_q[k-1];
      end
      ent_d[1] = '0;
      fwd_sel_d = '0;
      if (issue) begin
        ent_d[1].valid  = iss_regwrite_i & (iss_rd_i != '0);
        ent_d[1].rd     = FWD_RD_W'(iss_rd_i);
        ent_d[1].rdy_at = fwd_clamp(FWD_LAT_W'(iss_lat_i), DEPTH);
        fwd_sel_d       = op_sel;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ent_q     <= '0;
      fwd_sel_q <= '0;
    end else begin
      ent_q     <= ent_d;
      fwd_sel_q <= fwd_sel_d;
    end
  end

  assign fwd_sel_o = fwd_sel_q;

`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;
  logic [32:0] fwd_sum;
  logic [31:0] fwd_inc;

  always_comb begin
    fwd_inc = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      fwd_inc = fwd_inc + 32'(op_hit[s] & issue);
    end
    fwd_sum     = {1'b0, fwd_cnt_q} + {1'b0, fwd_inc};
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (!hold_i) begin
      if (stall_o && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
      fwd_cnt_d = fwd_sum[32] ? '1 : fwd_sum[31:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;
`else
  logic unused_hit;
  assign unused_hit = ^op_hit;
`endif

endmodule

`default_nettype wire

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the fixed two-stage EX/MEM forwarding logic.
- Tracks in-flight register writers across DEPTH pipeline stages, each with its own result-ready stage.
- Produces a registered per-operand forward select for NUM_SRC source operands of the issuing instruction.
- Raises a load-use style stall when the youngest producer's result is not yet available, and inserts the bubble itself.

Parameters:
- NUM_REGS, 32, architectural register count; register 0 is hardwired zero.
- AW, $clog2(NUM_REGS), register address width.
- DEPTH, 3, tracked stages beyond decode (1=EX, 2=MEM, 3=WB for the 5-stage core).
- NUM_SRC, 2, source operands checked per issue.
- SW, $clog2(DEPTH+1), forward-select width.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- hold_i  in  1  global freeze (e.g. cache miss); all state holds.
- flush_i  in  1  squash the instruction in decode; a bubble issues.
- iss_valid_i  in  1  decode holds a valid instruction.
- iss_regwrite_i  in  1  decode instruction writes a register.
- iss_rd_i  in  AW  destination register.
- iss_lat_i  in  SW  stage index at which the result becomes forwardable.
- src_addr_i  in  NUM_SRC*AW  source register addresses, operand j at slice j.
- src_used_i  in  NUM_SRC  operand j is actually read.
- fwd_sel_o  out  NUM_SRC*SW  per-operand select for the instruction now in stage 1; 0 = register file, k = stage k result.
- stall_o  out  1  decode must hold; combinational.

Behaviour:
- Entry array e[1..DEPTH], each holding {valid, rd, rdy_at}.
- Reset (async, asserted low): all entries invalid; fwd_sel_o=0; counters=0.
- Issue fires when iss_valid_i & !stall_o & !flush_i & !hold_i.
- Every clock with !hold_i:
  - e[k+1] <= e[k].
  - e[DEPTH] retires; its result is assumed written to the register file.
  - e[1] <= {iss_regwrite_i & (iss_rd_i!=0), iss_rd_i, clamp(iss_lat_i)} if issue fires, else an invalid bubble.
  - clamp: 0 maps to 1; values >DEPTH map to DEPTH.
- Match for operand j: src_used_i[j] & src_addr_i[j]!=0 & e[k].valid & e[k].rd==src_addr_i[j], for k in 1..DEPTH-1.
  - e[DEPTH] never matches; it is read from the register file.
  - Youngest (smallest k) match wins. The newest value has priority, unlike EX-over-MEM ordering bugs.
- Operand j stalls if the winning match has e[k].rdy_at > k+1.
- stall_o = iss_valid_i & !flush_i & OR over operands. It is combinational from entries and inputs.
- fwd_sel_o registered, updated when !hold_i:
  - Issue fires: operand j gets k+1 of the winning match, else 0.
  - Issue does not fire (bubble): all operands 0.
  - hold_i: fwd_sel_o retains its value.
- Latency: select visible the cycle after issue, aligned with the consumer in stage 1.
- Stall persists each cycle until the producer advances far enough. No deadlock is possible because the producer keeps shifting.
- flush_i and stall together: flush wins, a bubble issues, stall_o=0.
- hold_i and stall together: nothing shifts, stall_o stays asserted.
- Reset mid-operation: all in-flight tracking is discarded immediately.

Optional Feature:
- FWD_PERF_CNT_EN defined adds outputs stall_cnt_o[31:0] and fwd_cnt_o[31:0], both saturating and counting only when !hold_i.
  - stall_cnt_o increments on every cycle where stall_o=1.
  - fwd_cnt_o increments by the number of operands given a nonzero select at issue.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fwd_pkg holds:
  - typedef fwd_entry_t {valid, rd, rdy_at};
  - constant FWD_SEL_RF=0;
  - clamp function for rdy_at.
- Sub-module fwd_match: one operand's priority match over the entry array, returning {hit, sel, stall}. Instantiate NUM_SRC times with a generate loop.

Test Plan:
- ALU producer r5 (lat=2) issues, then next cycle consumer reads r5 on op0 -> no stall, fwd_sel op0=2 (stage 2).
- Load r7 (lat=3), then consumer reads r7 -> stall_o=1 for exactly one cycle, bubble issued, then fwd_sel=3.
- Two writers to r4 at e[1] and e[2], consumer reads r4 on both operands -> both selects =2 (youngest wins).
- Producer writes r0, consumer reads r0; also consumer with src_used_i=0 -> sel=0, no stall.
- Load-use stall with hold_i=1 for 3 cycles -> stall_o stays 1, entries and fwd_sel frozen; resumes with one more stall cycle.
- Assert rst_n_i low mid-stall -> stall_o=0 and fwd_sel_o=0 immediately; with FWD_PERF_CNT_EN, the counters clear.
